// File: rtl/simplez_ctrl.sv
// ============================================================================
// Module   : simplez_ctrl
// Function : Simplez microcontroller control unit. Sequences fetch, decode and
//            operand phases. Also handles memory ready stretching and timeout,
//            and counts retired instructions.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module simplez_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  co,
  input  logic        z,
  input  logic        mem_rdy,
  output logic        lec,
  output logic        esc,
  output logic        era,
  output logic        incp,
  output logic        ecp,
  output logic        ccp,
  output logic        scp,
  output logic        sri,
  output logic        eri,
  output logic        eac,
  output logic        sac,
  output logic [1:0]  alu_op,
  output logic        stop,
  output logic        err,
  output logic [2:0]  state_o,
  output logic [15:0] icount
);

  typedef enum logic [2:0] {
    S_R0     = 3'd0,
    S_R1     = 3'd1,
    S_I0     = 3'd2,
    S_I1     = 3'd3,
    S_O0     = 3'd4,
    S_O1     = 3'd5,
    S_HLT    = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  localparam logic [2:0] c_OP_ST   = 3'd0;
  localparam logic [2:0] c_OP_LD   = 3'd1;
  localparam logic [2:0] c_OP_ADD  = 3'd2;
  localparam logic [2:0] c_OP_BR   = 3'd3;
  localparam logic [2:0] c_OP_BZ   = 3'd4;
  localparam logic [2:0] c_OP_CLR  = 3'd5;
  localparam logic [2:0] c_OP_DEC  = 3'd6;
  localparam logic [2:0] c_OP_HALT = 3'd7;

  localparam logic [1:0] c_ALU_PASS = 2'd0;
  localparam logic [1:0] c_ALU_ADD  = 2'd1;
  localparam logic [1:0] c_ALU_DEC  = 2'd2;
  localparam logic [1:0] c_ALU_ZERO = 2'd3;

  localparam logic [7:0] c_TO_LAST = 8'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_icount;
  logic        r_err;
  logic [7:0]  r_wait_cnt;

  logic        w_lec, w_esc, w_era, w_incp, w_ecp, w_ccp;
  logic        w_scp, w_sri, w_eri, w_eac, w_sac, w_stop;
  logic [1:0]  w_alu_op;
  logic        w_retire;
  logic        w_waiting;
  logic        w_to_hit;
  logic        w_timeout;

  // Last permitted not-ready cycle of the current access.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait_cnt == c_TO_LAST);

  always_ff @(negedge clk) begin
    if (!rstn) begin
      r_state    <= S_R0;
      r_icount   <= 16'd0;
      r_err      <= 1'b0;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (w_retire)
        r_icount <= r_icount + 16'd1;
      if (w_to_hit)
        r_err <= 1'b1;
      // Any non-stall cycle precedes every entry to I0/O0, so clearing here
      // restarts the count for each access.
      if (w_waiting) begin
        if (r_wait_cnt != 8'hFF)
          r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lec     = 1'b0;
    w_esc     = 1'b0;
    w_era     = 1'b0;
    w_incp    = 1'b0;
    w_ecp     = 1'b0;
    w_ccp     = 1'b0;
    w_scp     = 1'b0;
    w_sri     = 1'b0;
    w_eri     = 1'b0;
    w_eac     = 1'b0;
    w_sac     = 1'b0;
    w_stop    = 1'b0;
    w_alu_op  = c_ALU_PASS;
    w_retire  = 1'b0;
    w_waiting = 1'b0;
    w_to_hit  = 1'b0;

    case (r_state)
      S_R0: begin
        w_ccp        = 1'b1;
        w_state_next = S_R1;
      end

      S_R1: begin
        w_scp        = 1'b1;
        w_era        = 1'b1;
        w_state_next = S_I0;
      end

      S_I0: begin
        w_lec = 1'b1;
        if (mem_rdy) begin
          w_eri        = 1'b1;
          w_incp       = 1'b1;
          w_state_next = S_I1;
        end else if (w_timeout) begin
          w_to_hit     = 1'b1;
          w_state_next = S_HLT;
        end else begin
          w_waiting = 1'b1;
        end
      end

      S_I1: begin
        case (co)
          c_OP_ST, c_OP_LD, c_OP_ADD: begin
            w_sri        = 1'b1;
            w_era        = 1'b1;
            w_state_next = S_O0;
          end
          c_OP_BR, c_OP_BZ: begin
            w_retire     = 1'b1;
            w_era        = 1'b1;
            w_state_next = S_I0;
            if (co == c_OP_BR || z) begin
              w_sri = 1'b1;
              w_ecp = 1'b1;
            end else begin
              w_scp = 1'b1;
            end
          end
          c_OP_CLR, c_OP_DEC: begin
            w_retire     = 1'b1;
            w_eac        = 1'b1;
            w_alu_op     = (co == c_OP_CLR) ? c_ALU_ZERO : c_ALU_DEC;
            w_scp        = 1'b1;
            w_era        = 1'b1;
            w_state_next = S_I0;
          end
          default: begin
            w_retire     = 1'b1;
            w_state_next = S_HLT;
          end
        endcase
      end

      S_O0: begin
        if (co == c_OP_ST) begin
          w_sac = 1'b1;
          w_esc = 1'b1;
        end else begin
          w_lec = 1'b1;
        end
        if (mem_rdy) begin
          w_retire     = 1'b1;
          w_state_next = S_O1;
          if (co != c_OP_ST) begin
            w_eac    = 1'b1;
            w_alu_op = (co == c_OP_ADD) ? c_ALU_ADD : c_ALU_PASS;
          end
        end else if (w_timeout) begin
          w_to_hit     = 1'b1;
          w_state_next = S_HLT;
        end else begin
          w_waiting = 1'b1;
        end
      end

      S_O1: begin
        w_scp        = 1'b1;
        w_era        = 1'b1;
        w_state_next = S_I0;
      end

      S_HLT: begin
        w_stop = 1'b1;
      end

      default: begin
        w_state_next = S_R0;
      end
    endcase
  end

  // Outputs are gated by rstn so a reset abandons any access immediately.
  assign lec     = rstn & w_lec;
  assign esc     = rstn & w_esc;
  assign era     = rstn & w_era;
  assign incp    = rstn & w_incp;
  assign ecp     = rstn & w_ecp;
  assign ccp     = rstn & w_ccp;
  assign scp     = rstn & w_scp;
  assign sri     = rstn & w_sri;
  assign eri     = rstn & w_eri;
  assign eac     = rstn & w_eac;
  assign sac     = rstn & w_sac;
  assign stop    = rstn & w_stop;
  assign alu_op  = rstn ? w_alu_op : 2'd0;
  assign err     = rstn & r_err;
  assign state_o = rstn ? r_state : S_R0;
  assign icount  = rstn ? r_icount : 16'd0;

endmodule

`default_nettype wire

// File: tb/tb_simplez_ctrl.sv
// ============================================================================
// Module   : tb_simplez_ctrl
// Function : Self-checking bench for simplez_ctrl with randomized programs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_simplez_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  co = 3'd0;
  logic        z = 1'b0;
  logic        mem_rdy = 1'b0;
  logic        lec, esc, era, incp, ecp, ccp, scp, sri, eri, eac, sac, stop, err;
  logic [1:0]  alu_op;
  logic [2:0]  state_o;
  logic [15:0] icount;

  simplez_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .co(co), .z(z), .mem_rdy(mem_rdy),
    .lec(lec), .esc(esc), .era(era), .incp(incp), .ecp(ecp), .ccp(ccp),
    .scp(scp), .sri(sri), .eri(eri), .eac(eac), .sac(sac), .alu_op(alu_op),
    .stop(stop), .err(err), .state_o(state_o), .icount(icount)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] U_LEC  = 14'h2000;
  localparam logic [13:0] U_ESC  = 14'h1000;
  localparam logic [13:0] U_ERA  = 14'h0800;
  localparam logic [13:0] U_INCP = 14'h0400;
  localparam logic [13:0] U_ECP  = 14'h0200;
  localparam logic [13:0] U_CCP  = 14'h0100;
  localparam logic [13:0] U_SCP  = 14'h0080;
  localparam logic [13:0] U_SRI  = 14'h0040;
  localparam logic [13:0] U_ERI  = 14'h0020;
  localparam logic [13:0] U_EAC  = 14'h0010;
  localparam logic [13:0] U_SAC  = 14'h0008;
  localparam logic [13:0] U_STOP = 14'h0001;

  // Observed word: {microorders, state, icount, err}.
  wire [33:0] obs = {lec, esc, era, incp, ecp, ccp, scp, sri, eri, eac, sac,
                     alu_op, stop, state_o, icount, err};

  int n_checks = 0;
  int n_fail = 0;
  int exp_icount = 0;
  logic [33:0] exp_w;

  function automatic logic [13:0] u_alu(input int a);
    return 14'(a << 1);
  endfunction

  // Decode-phase microorders from the opcode table.
  function automatic logic [13:0] exp_decode(input logic [2:0] c, input logic zz);
    case (c)
      3'd0, 3'd1, 3'd2: return U_SRI | U_ERA;
      3'd3:             return U_SRI | U_ERA | U_ECP;
      3'd4:             return zz ? (U_SRI | U_ERA | U_ECP) : (U_SCP | U_ERA);
      3'd5:             return U_EAC | u_alu(3) | U_SCP | U_ERA;
      3'd6:             return U_EAC | u_alu(2) | U_SCP | U_ERA;
      default:          return 14'h0;
    endcase
  endfunction

  // Drive one cycle's inputs mid-cycle (state updates on the falling edge).
  task automatic tick(input logic [2:0] c, input logic zz, input logic rdy, input logic rs);
    @(posedge clk);
    co = c; z = zz; mem_rdy = rdy; rstn = rs;
    #1;
  endtask

  task automatic restart();
    for (int k = 0; k < 3; k++) begin
      tick(3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      n_checks++;
      if (obs !== 34'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h expected %h", obs, 34'h0);
      end
    end
    exp_icount = 0;
    tick(3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    exp_w = {U_CCP, 3'd0, 16'd0, 1'b0};
    n_checks++;
    if (obs !== exp_w) begin
      n_fail++;
      $display("FAIL r0: got %h expected %h", obs, exp_w);
    end
    tick(3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    exp_w = {U_SCP | U_ERA, 3'd1, 16'd0, 1'b0};
    n_checks++;
    if (obs !== exp_w) begin
      n_fail++;
      $display("FAIL r1: got %h expected %h", obs, exp_w);
    end
  endtask

  // One complete instruction with si/so not-ready cycles in fetch/operand.
  task automatic exec_instr(input logic [2:0] c, input logic zz, input int si, input int so);
    for (int k = 0; k <= si; k++) begin
      tick(3'($urandom), 1'($urandom), (k == si), 1'b1);
      exp_w = {U_LEC | ((k == si) ? (U_ERI | U_INCP) : 14'h0), 3'd2, 16'(exp_icount), 1'b0};
      n_checks++;
      if (obs !== exp_w) begin
        n_fail++;
        $display("FAIL fetch op=%0d k=%0d: got %h expected %h", c, k, obs, exp_w);
      end
    end
    tick(c, zz, 1'($urandom), 1'b1);
    exp_w = {exp_decode(c, zz), 3'd3, 16'(exp_icount), 1'b0};
    n_checks++;
    if (obs !== exp_w) begin
      n_fail++;
      $display("FAIL decode op=%0d z=%b: got %h expected %h", c, zz, obs, exp_w);
    end
    if (c >= 3'd3) exp_icount = (exp_icount + 1) % 65536;
    if (c <= 3'd2) begin
      for (int k = 0; k <= so; k++) begin
        tick(c, 1'($urandom), (k == so), 1'b1);
        if (c == 3'd0)
          exp_w = {U_SAC | U_ESC, 3'd4, 16'(exp_icount), 1'b0};
        else
          exp_w = {U_LEC | ((k == so) ? (U_EAC | u_alu(c == 3'd2 ? 1 : 0)) : 14'h0),
                   3'd4, 16'(exp_icount), 1'b0};
        n_checks++;
        if (obs !== exp_w) begin
          n_fail++;
          $display("FAIL operand op=%0d k=%0d: got %h expected %h", c, k, obs, exp_w);
        end
      end
      exp_icount = (exp_icount + 1) % 65536;
      tick(3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      exp_w = {U_SCP | U_ERA, 3'd5, 16'(exp_icount), 1'b0};
      n_checks++;
      if (obs !== exp_w) begin
        n_fail++;
        $display("FAIL o1 op=%0d: got %h expected %h", c, obs, exp_w);
      end
    end else if (c == 3'd7) begin
      tick(3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      exp_w = {U_STOP, 3'd6, 16'(exp_icount), 1'b0};
      n_checks++;
      if (obs !== exp_w) begin
        n_fail++;
        $display("FAIL halt_entry: got %h expected %h", obs, exp_w);
      end
    end
  endtask

  task automatic test_reset();
    restart();
    exec_instr(3'd7, 1'b0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      exp_w = {U_STOP, 3'd6, 16'd1, 1'b0};
      n_checks++;
      if (obs !== exp_w) begin
        n_fail++;
        $display("FAIL halt_hold: got %h expected %h", obs, exp_w);
      end
    end
  endtask

  task automatic test_ld_add_st();
    restart();
    exec_instr(3'd1, 1'b0, 0, 0);
    exec_instr(3'd2, 1'b1, 0, 0);
    exec_instr(3'd0, 1'b0, 0, 0);
    n_checks++;
    if (icount !== 16'd3) begin
      n_fail++;
      $display("FAIL icount_after_st: got %0d expected 3", icount);
    end
  endtask

  task automatic test_bz();
    restart();
    exec_instr(3'd4, 1'b1, 0, 0);
    exec_instr(3'd4, 1'b0, 0, 0);
    exec_instr(3'd3, 1'b0, 0, 0);
  endtask

  task automatic test_wait_states();
    restart();
    exec_instr(3'd5, 1'b0, 3, 0);
    exec_instr(3'd1, 1'b0, 2, 3);
    exec_instr(3'd0, 1'b1, 1, 3);
  endtask

  task automatic test_random();
    restart();
    for (int n = 0; n < 60; n++)
      exec_instr(3'($urandom_range(0, 6)), 1'($urandom), $urandom_range(0, TO - 1),
                 $urandom_range(0, TO - 1));
    exec_instr(3'd7, 1'($urandom), $urandom_range(0, TO - 1), 0);
  endtask

  task automatic test_timeout();
    // Operand access stuck not-ready: halts with err after TO cycles.
    restart();
    tick(3'd0, 1'b0, 1'b1, 1'b1);
    tick(3'd0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < TO; k++) begin
      tick(3'd0, 1'($urandom), 1'b0, 1'b1);
      exp_w = {U_SAC | U_ESC, 3'd4, 16'd0, 1'b0};
      n_checks++;
      if (obs !== exp_w) begin
        n_fail++;
        $display("FAIL to_stall k=%0d: got %h expected %h", k, obs, exp_w);
      end
    end
    tick(3'd0, 1'b0, 1'b1, 1'b1);
    exp_w = {U_STOP, 3'd6, 16'd0, 1'b1};
    n_checks++;
    if (obs !== exp_w) begin
      n_fail++;
      $display("FAIL to_halt: got %h expected %h", obs, exp_w);
    end
    // Ready arriving on the last permitted cycle wins.
    restart();
    exec_instr(3'd0, 1'b0, 0, TO - 1);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_rdy_wins: got err=%b expected 0", err);
    end
    // Fetch stuck not-ready.
    restart();
    for (int k = 0; k < TO; k++) tick(3'd0, 1'b0, 1'b0, 1'b1);
    tick(3'd0, 1'b0, 1'b1, 1'b1);
    exp_w = {U_STOP, 3'd6, 16'd0, 1'b1};
    n_checks++;
    if (obs !== exp_w) begin
      n_fail++;
      $display("FAIL to_fetch: got %h expected %h", obs, exp_w);
    end
  endtask

  task automatic test_mid_reset();
    restart();
    exec_instr(3'd6, 1'b0, 0, 0);
    tick(3'd1, 1'b0, 1'b1, 1'b1);
    tick(3'd1, 1'b0, 1'b0, 1'b1);
    tick(3'd1, 1'b0, 1'b0, 1'b1);
    tick(3'd1, 1'b0, 1'b0, 1'b1);
    exp_w = {U_LEC, 3'd4, 16'd1, 1'b0};
    n_checks++;
    if (obs !== exp_w) begin
      n_fail++;
      $display("FAIL mid_stall: got %h expected %h", obs, exp_w);
    end
    tick(3'd1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 34'h0) begin
      n_fail++;
      $display("FAIL mid_reset_drop: got %h expected %h", obs, 34'h0);
    end
    restart();
    exec_instr(3'd2, 1'b0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ld_add_st();
    test_bz();
    test_wait_states();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/simplez_ctrl.md
# simplez_ctrl

Control unit for the Simplez microcontroller. Sequences the 12-bit-data / 9-bit-address datapath (CP, RA, RI, AC, ALU, memory) through fetch, decode and operand phases by driving the microorders each clock. Stretches memory accesses with a ready handshake, aborts hung accesses with a timeout, and counts retired instructions. Instantiated next to the datapath inside `simplez`; it replaces the inline I0/I1 sequencer.

## Interface
- `MEM_TIMEOUT`, default 15: maximum consecutive not-ready cycles per memory access (1..255); 0 disables the timeout.
- `clk`  in  1  clock; all state updates on the falling edge, matching the datapath.
- `rstn`  in  1  reset, synchronous, active-low.
- `co`  in  3  opcode, RI[11:9]: ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7.
- `z`  in  1  AC == 0 flag from the datapath.
- `mem_rdy`  in  1  memory completes the current read/write in this cycle.
- `lec`, `esc`  out  1 each  memory read / write strobe.
- `era`  out  1  load RA from busAi.
- `incp`, `ecp`, `ccp`  out  1 each  CP increment / load from busAi / clear.
- `scp`, `sri`  out  1 each  drive busAi from CP / RI.CD.
- `eri`  out  1  load RI from busD.
- `eac`, `sac`  out  1 each  load AC from ALU / drive busD from AC.
- `alu_op`  out  2  0 PASS busD, 1 AC+busD, 2 AC−1, 3 zero.
- `stop`  out  1  processor halted.
- `err`  out  1  sticky memory-timeout flag.
- `state_o`  out  3  current state code (LED monitor).
- `icount`  out  16  retired-instruction counter.

## Operation
- State codes: R0=0, R1=1, I0=2, I1=3, O0=4, O1=5, HLT=6; 7 is unused and goes to R0.
- All microorders are combinational decodes of state, `co`, `z` and `mem_rdy`. Any microorder not listed for a state is 0, and `alu_op` is 0.
- **R0:** `ccp` → R1.
- **R1:** `scp`, `era` → I0. RA = 0.
- **I0 (fetch):**
  - `lec` is held high.
  - When `mem_rdy`=1: `eri`, `incp`, → I1.
  - Otherwise stay in I0.
- **I1 (decode), by opcode:**
  - ST/LD/ADD: `sri`, `era` → O0.
  - BR, or BZ with z=1: `sri`, `era`, `ecp` → I0.
  - BZ with z=0: `scp`, `era` → I0.
  - CLR: `eac`, alu_op=3, `scp`, `era` → I0.
  - DEC: `eac`, alu_op=2, `scp`, `era` → I0.
  - HALT: → HLT.
- **O0 (operand):**
  - LD/ADD: `lec` held high; when `mem_rdy`: `eac`, alu_op=0 (LD) or 1 (ADD), → O1.
  - ST: `sac` and `esc` held high; when `mem_rdy` → O1.
- **O1:** `scp`, `era` → I0.
- **HLT:** `stop`=1, no microorders. Left only by reset.
- **`icount` increments (mod 2^16)** on:
  - the I1 edge for BR/BZ/CLR/DEC/HALT;
  - the O0 edge with `mem_rdy` for ST/LD/ADD.
- **Timeout:**
  - An 8-bit `wait_cnt` clears on entry to I0 or O0 and increments each I0/O0 cycle with `mem_rdy`=0.
  - If `mem_rdy`=0 and `wait_cnt` = MEM_TIMEOUT−1, the edge goes to HLT with `err`=1.
  - `mem_rdy`=1 in that same cycle wins: normal transition, no error.
- `co` must be stable from the I1 edge through O0 (RI only loads in I0).

## Timing
- Reset values (rstn=0 at an edge): state=R0, `icount`=0, `err`=0, `wait_cnt`=0.
- While rstn=0, all microorders and `stop` are forced to 0 and `state_o` reads 0.
- Reset mid-access abandons the access: `esc`/`lec` drop in the same cycle rstn falls.
- First fetch is 2 cycles after rstn releases (R0, R1, then I0).
- With `mem_rdy` tied 1:
  - ST/LD/ADD take 4 cycles (I0, I1, O0, O1).
  - BR/BZ/CLR/DEC take 2 cycles.
  - HALT reaches HLT 2 cycles after I0.
- Each not-ready cycle adds exactly 1 cycle. Strobes stay asserted and stable throughout the stall.
- `eri`, `eac` and `incp` are asserted only in the `mem_rdy` cycle, never during stalls.

## Test plan
- **Reset, HALT at address 0:** `mem_rdy`=1, co=7 → `state_o` sequence 0,1,2,3,6; `stop`=1 from the 5th cycle; `icount`=1; `ccp` in R0, `era` in R1.
- **LD then ADD then ST:** `mem_rdy`=1 → each takes 4 cycles.
  - O0 shows `lec`+`eac` with alu_op 0, then `lec`+`eac` with alu_op 1, then `sac`+`esc`.
  - `icount`=3 after the ST's O0.
- **BZ:**
  - z=1 → I1 asserts `sri`, `era`, `ecp`.
  - z=0 → I1 asserts `scp`, `era`, no `ecp`.
  - Both return to I0 next cycle.
- **Wait states:** `mem_rdy` low 3 cycles in I0 → `lec`=1 for 4 cycles; `eri` and `incp` high only in the 4th; no `err`.
- **Timeout:** MEM_TIMEOUT=4, ST with `mem_rdy` stuck 0 → after 4 O0 cycles state=6, `err`=1, `stop`=1.
  - Repeat with `mem_rdy`=1 in the 4th cycle → O1, `err`=0.
- **Mid-operation reset:** drop rstn during an O0 stall → all outputs 0 immediately; `state_o`=0; `icount`=0; restart resumes with R0, R1, I0.
